param_lifo_stack: RTL

- Parametrised LIFO stack for the maze-solver datapath; stores visited-location words pushed by the controller FSM and returns them on backtrack.
- Generalises the 8-bit location stack to configurable width and depth.
- Adds full/empty/count status, registered pop data with a valid strobe, a combinational top-of-stack peek, and defined simultaneous push+pop (replace-top) semantics.

---
 rtl/lifo_stack_pkg.sv | 23 ++
 rtl/lifo_stack_mem.sv | 26 ++
 rtl/param_lifo_stack.sv | 97 +++++++++
 3 files changed

// File: rtl/lifo_stack_pkg.sv
// rtl/lifo_stack_pkg.sv - shared defaults, operation encoding and decode for the LIFO stack
package lifo_stack_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // Push+pop on an empty stack degrades to a plain push; illegal ops become OP_NONE.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    if (push && pop) return empty ? OP_PUSH : OP_REPLACE;
    if (push)        return full ? OP_NONE : OP_PUSH;
    if (pop)         return empty ? OP_NONE : OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// rtl/lifo_stack_mem.sv - single write port storage with asynchronous read, no reset
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Left unreset so synthesis can map it onto distributed RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo_stack.sv
// rtl/param_lifo_stack.sv - parametrised LIFO stack; LIFO_STACK_ERR_EN adds sticky overflow/underflow flags
module param_lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
`ifdef LIFO_STACK_ERR_EN
  ,
  input  logic              err_clr,
  output logic              err_ovf,
  output logic              err_udf
`endif
);

  localparam int AW = $clog2(DEPTH);

  stack_op_e         op;
  logic [AW-1:0]     top_addr;
  logic [AW-1:0]     wr_addr;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign op    = decode_op(push, pop, empty, full);

  // count is the next free slot; the top entry sits one below it.
  assign top_addr = AW'(count - CNT_W'(1));
  assign wr_addr  = (op == OP_PUSH) ? AW'(count) : top_addr;
  assign wr_en    = (op == OP_PUSH) || (op == OP_REPLACE);
  assign top      = empty ? '0 : rd_data;

  lifo_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (din),
    .raddr (top_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP: begin
          count      <= count - CNT_W'(1);
          dout       <= rd_data;
          dout_valid <= 1'b1;
        end
        OP_REPLACE: begin
          dout       <= rd_data;
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIFO_STACK_ERR_EN
  // A new violation in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (push && !pop && full)       err_ovf <= 1'b1;
      else if (err_clr)               err_ovf <= 1'b0;
      if (pop && !push && empty)      err_udf <= 1'b1;
      else if (err_clr)               err_udf <= 1'b0;
    end
  end
`endif

endmodule
